// File: rtl/subleq_mmio_fifo_pkg.sv
// Shared constants and types for the subleq MMIO decoder with host FIFOs.
// The I/O window is the top four addresses; the two LSBs select the register.
package subleq_mmio_fifo_pkg;

  localparam int unsigned WORD_SIZE_DEFAULT = 16;

  // Ack sequencer states: accept in IDLE, ack for one cycle, then ignore one cycle.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACK  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // T-1 HALT, T-2 OUT, T-3 IN, T-4 STATUS, keyed by addr[1:0].
  typedef enum logic [1:0] {
    IO_STATUS = 2'd0,
    IO_IN     = 2'd1,
    IO_OUT    = 2'd2,
    IO_HALT   = 2'd3
  } io_sel_t;

  // Status word payload, bit 3 down to bit 0.
  typedef struct packed {
    logic eof_flag;
    logic out_full;
    logic out_empty;
    logic in_empty;
  } status_t;

endpackage

// File: rtl/subleq_fifo.sv
// Small synchronous FIFO with a registered head pointer; head reads 0 while empty.
module subleq_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/subleq_mmio_fifo.sv
// MMIO decoder between the subleq CPU and memory / host I/O, with input and
// output FIFOs, a status register and a sticky halt flag.
module subleq_mmio_fifo
  import subleq_mmio_fifo_pkg::*;
#(
  parameter int unsigned WORD_SIZE = WORD_SIZE_DEFAULT,
  parameter int unsigned IN_DEPTH  = 4,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 eof,
  input  logic                 in_ack,
  output logic                 in_req,
  input  logic [WORD_SIZE-1:0] io_in,
  input  logic                 out_ack,
  output logic                 out_req,
  output logic [WORD_SIZE-1:0] io_out,
  input  logic                 cpu_req,
  input  logic                 cpu_load,
  input  logic                 cpu_store,
  input  logic [WORD_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] data_out,
  output logic                 cpu_ack,
  output logic                 cpu_halt,
  output logic [WORD_SIZE-1:0] data_in,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_out,
  output logic                 mem_req,
  output logic                 mem_load,
  output logic                 mem_store,
  output logic [WORD_SIZE-1:0] mem_in,
  output logic [WORD_SIZE-1:0] mem_addr
);

  logic [1:0]           state_q, state_d;
  logic                 halt_q, halt_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic [WORD_SIZE-1:0] rd_sel;
  logic                 accept;
  logic                 io_space;
  io_sel_t              sel;
  status_t              status;

  logic                 in_full, in_empty, in_pop;
  logic [WORD_SIZE-1:0] in_head;
  logic                 out_full, out_empty, out_push;

  subleq_fifo #(.WIDTH(WORD_SIZE), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_req && in_ack),
    .push_data (io_in),
    .pop       (in_pop),
    .full      (in_full),
    .empty     (in_empty),
    .head      (in_head)
  );

  subleq_fifo #(.WIDTH(WORD_SIZE), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (out_push),
    .push_data (data_out),
    .pop       (out_req && out_ack),
    .full      (out_full),
    .empty     (out_empty),
    .head      (io_out)
  );

  assign io_space = &addr[WORD_SIZE-1:2];
  assign sel      = io_sel_t'(addr[1:0]);
  assign status   = '{eof_flag: eof, out_full: out_full, out_empty: out_empty, in_empty: in_empty};

  assign in_req   = !in_full && !eof && !halt_q;
  assign out_req  = !out_empty;
  assign cpu_halt = halt_q;

  // Memory space is a straight pass-through; I/O space silences the memory bus.
  assign mem_req   = cpu_req   && !io_space;
  assign mem_load  = cpu_load  && !io_space;
  assign mem_store = cpu_store && !io_space;
  assign mem_in    = io_space ? '0 : data_out;
  assign mem_addr  = io_space ? '0 : addr;
  assign cpu_ack   = io_space ? (state_q == S_ACK) : mem_ack;
  assign data_in   = io_space ? rdata_q : mem_out;

  // Next-state, side effects and read data for I/O requests.
  always_comb begin
    state_d  = state_q;
    halt_d   = halt_q;
    rdata_d  = rdata_q;
    rd_sel   = '0;
    accept   = 1'b0;
    in_pop   = 1'b0;
    out_push = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req && io_space) begin
          accept = 1'b1;
          if (halt_q) begin
            // Halted: still ack everything, but only the status read returns data.
            if (sel == IO_STATUS && cpu_load) rd_sel = WORD_SIZE'(status);
          end else begin
            case (sel)
              IO_HALT: halt_d = 1'b1;
              IO_OUT: begin
                if (cpu_store) begin
                  if (out_full) accept = 1'b0;
                  else          out_push = 1'b1;
                end
              end
              IO_IN: begin
                if (cpu_load) begin
                  if (!in_empty) begin
                    in_pop = 1'b1;
                    rd_sel = in_head;
                  end else if (eof) begin
                    halt_d = 1'b1;
                  end else begin
                    accept = 1'b0;
                  end
                end
              end
              IO_STATUS: begin
                if (cpu_load) rd_sel = WORD_SIZE'(status);
              end
              default: ;
            endcase
          end
          if (accept) begin
            state_d = S_ACK;
            rdata_d = rd_sel;
          end
        end
      end
      S_ACK:   state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      halt_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_subleq_mmio_fifo.sv
// Scoreboard bench for subleq_mmio_fifo (WORD_SIZE 8, depth-2 FIFOs): a queue-based
// reference model predicts I/O acks and host traffic, a negedge monitor compares.
module tb_subleq_mmio_fifo;

  localparam int unsigned W  = 8;
  localparam int unsigned ID = 2;
  localparam int unsigned OD = 2;

  logic         clk, rst, eof, in_ack, in_req, out_ack, out_req;
  logic         cpu_req, cpu_load, cpu_store, cpu_ack, cpu_halt;
  logic         mem_ack, mem_req, mem_load, mem_store;
  logic [W-1:0] io_in, io_out, addr, data_out, data_in, mem_out, mem_in, mem_addr;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] in_q[$];
  logic [W-1:0] out_q[$];
  logic [W-1:0] exp_cpu[$];
  logic [W-1:0] src[$];
  bit           halt_m;
  int           busy;

  // Stimulus knobs
  bit in_always, src_rand, out_auto, mem_auto;

  subleq_mmio_fifo #(.WORD_SIZE(W), .IN_DEPTH(ID), .OUT_DEPTH(OD)) dut (
    .clk(clk), .rst(rst), .eof(eof), .in_ack(in_ack), .in_req(in_req), .io_in(io_in),
    .out_ack(out_ack), .out_req(out_req), .io_out(io_out),
    .cpu_req(cpu_req), .cpu_load(cpu_load), .cpu_store(cpu_store), .addr(addr),
    .data_out(data_out), .cpu_ack(cpu_ack), .cpu_halt(cpu_halt), .data_in(data_in),
    .mem_ack(mem_ack), .mem_out(mem_out), .mem_req(mem_req), .mem_load(mem_load),
    .mem_store(mem_store), .mem_in(mem_in), .mem_addr(mem_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] status_m();
    return W'({eof, out_q.size() == OD, out_q.size() == 0, in_q.size() == 0});
  endfunction

  // Reference model: advances once per clock from the inputs present before the edge.
  always @(posedge clk) begin : model
    logic [W-1:0] d;
    bit acc, pop_in, push_out, in_req_m, out_pop, halt0;
    if (rst) begin
      in_q.delete();
      out_q.delete();
      exp_cpu.delete();
      halt_m = 1'b0;
      busy   = 0;
    end else begin
      in_req_m = (in_q.size() < ID) && !eof && !halt_m;
      out_pop  = (out_q.size() > 0) && out_ack;
      halt0    = halt_m;
      pop_in   = 1'b0;
      push_out = 1'b0;
      if (busy > 0) begin
        busy--;
      end else if (cpu_req && addr >= 8'hFC) begin
        acc = 1'b1;
        d   = '0;
        if (halt0) begin
          if (addr == 8'hFC && cpu_load) d = status_m();
        end else if (addr == 8'hFF) begin
          halt_m = 1'b1;
        end else if (addr == 8'hFE) begin
          if (cpu_store) begin
            if (out_q.size() == OD) acc = 1'b0;
            else                    push_out = 1'b1;
          end
        end else if (addr == 8'hFD) begin
          if (cpu_load) begin
            if (in_q.size() > 0) begin d = in_q[0]; pop_in = 1'b1; end
            else if (eof)        halt_m = 1'b1;
            else                 acc = 1'b0;
          end
        end else if (cpu_load) begin
          d = status_m();
        end
        if (acc) begin
          exp_cpu.push_back(d);
          busy = 2;
        end
      end
      if (out_pop)  void'(out_q.pop_front());
      if (push_out) out_q.push_back(data_out);
      if (pop_in)   void'(in_q.pop_front());
      if (in_req_m && in_ack) begin
        in_q.push_back(io_in);
        if (src.size() > 0) void'(src.pop_front());
      end
    end
  end

  // Host and memory side stimulus.
  always @(posedge clk) begin
    #1;
    if (src_rand && src.size() < 3) src.push_back(W'($urandom));
    in_ack = (src.size() > 0) && (in_always || ($urandom_range(0, 1) == 1));
    io_in  = (src.size() > 0) ? src[0] : W'($urandom);
    if (out_auto) out_ack = ($urandom_range(0, 1) == 1);
    if (mem_auto) begin
      mem_ack = 1'($urandom);
      mem_out = W'($urandom);
    end
  end

  // Monitor: compares every visible output against the model between edges.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_req", 32'(in_req), 32'((in_q.size() < ID) && !eof && !halt_m));
      chk("out_req", 32'(out_req), 32'(out_q.size() > 0));
      chk("io_out", 32'(io_out), 32'((out_q.size() > 0) ? out_q[0] : W'(0)));
      chk("cpu_halt", 32'(cpu_halt), 32'(halt_m));
      if (addr >= 8'hFC) begin
        chk("io_ack", 32'(cpu_ack), 32'(busy == 2));
        if (busy == 2 && exp_cpu.size() > 0) chk("io_data", 32'(data_in), 32'(exp_cpu.pop_front()));
        chk("io_mem_quiet", 32'({mem_req, mem_load, mem_store, mem_in, mem_addr}), 32'(0));
      end else begin
        chk("mem_ack", 32'(cpu_ack), 32'(mem_ack));
        chk("mem_data", 32'(data_in), 32'(mem_out));
        chk("mem_ctl", 32'({mem_req, mem_load, mem_store}), 32'({cpu_req, cpu_load, cpu_store}));
        chk("mem_bus", 32'({mem_addr, mem_in}), 32'({addr, data_out}));
      end
    end
  end

  task automatic io_op(input logic [W-1:0] a, input logic ld, input logic st, input logic [W-1:0] d);
    int n;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_load = ld; cpu_store = st; addr = a; data_out = d;
    n = 0;
    @(negedge clk);
    while (!cpu_ack && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("io_ack_seen", 32'(cpu_ack), 32'(1));
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_load = 1'b0; cpu_store = 1'b0;
  endtask

  task automatic mem_op(input logic [W-1:0] a, input logic ld, input logic ack, input logic [W-1:0] mo);
    @(posedge clk); #1;
    mem_auto = 1'b0;
    cpu_req = 1'b1; cpu_load = ld; cpu_store = !ld; addr = a; data_out = W'($urandom);
    mem_ack = ack; mem_out = mo;
    @(negedge clk);
    chk("mem_op_ack", 32'(cpu_ack), 32'(ack));
    chk("mem_op_data", 32'(data_in), 32'(mo));
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_load = 1'b0; cpu_store = 1'b0; addr = '0;
    mem_auto = 1'b1;
  endtask

  initial begin
    rst = 1'b1; eof = 1'b0;
    cpu_req = 1'b0; cpu_load = 1'b0; cpu_store = 1'b0; addr = '0; data_out = '0;
    mem_ack = 1'b0; mem_out = '0; in_ack = 1'b0; io_in = '0; out_ack = 1'b0;
    in_always = 1'b0; src_rand = 1'b0; out_auto = 1'b0; mem_auto = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'(0));
    chk("rst_halt", 32'(cpu_halt), 32'(0));
    chk("rst_in_req", 32'(in_req), 32'(1));
    chk("rst_out_req", 32'(out_req), 32'(0));
    chk("rst_io_out", 32'(io_out), 32'(0));
    chk("rst_data_in", 32'(data_in), 32'(0));

    // Input fill stops at depth, CPU pop lets the third word in
    @(posedge clk); #1;
    src = '{8'h11, 8'h22, 8'h33};
    in_always = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("in_full_stall", 32'(in_req), 32'(0));
    io_op(8'hFD, 1'b1, 1'b0, 8'h00);
    repeat (4) @(posedge clk);

    // Output full stalls the store until the host drains one word
    io_op(8'hFE, 1'b0, 1'b1, 8'hA1);
    io_op(8'hFE, 1'b0, 1'b1, 8'hB2);
    fork
      io_op(8'hFE, 1'b0, 1'b1, 8'h5A);
      begin
        repeat (8) @(posedge clk);
        #1 out_ack = 1'b1;
        @(posedge clk);
        #1 out_ack = 1'b0;
      end
    join
    @(posedge clk); #1 out_ack = 1'b1;
    repeat (4) @(posedge clk);
    #1 out_ack = 1'b0;

    // Memory pass-through
    mem_op(8'h10, 1'b1, 1'b1, 8'h7E);

    // Randomised mix
    src_rand = 1'b1; in_always = 1'b0; out_auto = 1'b1;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 7))
        0, 1: io_op(8'hFD, 1'b1, 1'b0, 8'h00);
        2, 3: io_op(8'hFE, 1'b0, 1'b1, W'($urandom));
        4:    io_op(8'hFC, 1'b1, 1'b0, 8'h00);
        5:    mem_op(W'($urandom_range(0, 251)), 1'($urandom), 1'($urandom), W'($urandom));
        6: begin
          case ($urandom_range(0, 2))
            0:       io_op(8'hFE, 1'b1, 1'b0, 8'h00);
            1:       io_op(8'hFD, 1'b0, 1'b1, W'($urandom));
            default: io_op(8'hFC, 1'b0, 1'b1, W'($urandom));
          endcase
        end
        default: repeat ($urandom_range(1, 4)) @(posedge clk);
      endcase
    end

    // HALT store; queued output keeps draining afterwards
    @(posedge clk); #1;
    src_rand = 1'b0; out_auto = 1'b0; out_ack = 1'b1;
    repeat (4) @(posedge clk);
    #1 out_ack = 1'b0;
    io_op(8'hFE, 1'b0, 1'b1, 8'hC1);
    io_op(8'hFE, 1'b0, 1'b1, 8'hC2);
    io_op(8'hFF, 1'b0, 1'b1, 8'h00);
    @(negedge clk);
    chk("halt_set", 32'(cpu_halt), 32'(1));
    chk("halt_out_pending", 32'(out_req), 32'(1));
    @(posedge clk); #1 out_ack = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("halt_drained", 32'(out_req), 32'(0));
    chk("halt_sticky", 32'(cpu_halt), 32'(1));

    // eof with empty input FIFO halts and returns 0; status shows eof
    @(posedge clk); #1;
    out_ack = 1'b0; rst = 1'b1; src.delete(); in_always = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; src = '{8'h66};
    repeat (3) @(posedge clk);
    #1 eof = 1'b1;
    io_op(8'hFD, 1'b1, 1'b0, 8'h00);
    io_op(8'hFD, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("eof_halt", 32'(cpu_halt), 32'(1));
    io_op(8'hFC, 1'b1, 1'b0, 8'h00);
    io_op(8'hFD, 1'b1, 1'b0, 8'h00);

    // Reset landing on the accepting edge discards the ack and FIFO contents
    @(posedge clk); #1;
    rst = 1'b1; eof = 1'b0; src.delete();
    @(posedge clk); #1;
    rst = 1'b0; src = '{8'h44, 8'h55};
    repeat (4) @(posedge clk);
    #1;
    cpu_req = 1'b1; cpu_load = 1'b1; addr = 8'hFD; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cpu_req = 1'b0; cpu_load = 1'b0;
    @(negedge clk);
    chk("rst_mid_ack", 32'(cpu_ack), 32'(0));
    chk("rst_mid_in_req", 32'(in_req), 32'(1));
    chk("rst_mid_out_req", 32'(out_req), 32'(0));
    io_op(8'hFC, 1'b1, 1'b0, 8'h00);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/subleq_mmio_fifo.md
Name: subleq_mmio_fifo

Overview:
Second-generation MMIO decoder between the subleq CPU and memory/host I/O. Adds parametrised input and output FIFOs that decouple host handshakes from CPU accesses, a readable status word, and a sticky halt flag. Memory-space accesses still pass through combinationally. I/O-space accesses get a registered one-cycle ack.

Parameters:
WORD_SIZE, `WORD_SIZE (16), data/address width.
IN_DEPTH, 4, input FIFO entries; power of two, >= 2.
OUT_DEPTH, 4, output FIFO entries; power of two, >= 2.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
eof  in  1  host input exhausted.
in_ack  in  1  host input word valid on io_in.
in_req  out  1  block requests an input word.
io_in  in  WORD_SIZE  host input data.
out_ack  in  1  host accepted io_out.
out_req  out  1  io_out valid.
io_out  out  WORD_SIZE  output FIFO head.
cpu_req, cpu_load, cpu_store, addr, data_out  in  1/1/1/WORD_SIZE/WORD_SIZE  CPU request, read, write, address, write data.
cpu_ack, cpu_halt, data_in  out  1/1/WORD_SIZE  CPU ack, halt, read data.
mem_ack, mem_out  in  1/WORD_SIZE  memory ack and read data.
mem_req, mem_load, mem_store, mem_in, mem_addr  out  1/1/1/WORD_SIZE/WORD_SIZE  memory request, read, write, write data, address.

Behaviour:
- Map with T = 2^WORD_SIZE: T-1 HALT, T-2 OUT (store), T-3 IN (load), T-4 STATUS (load). addr >= T-4 is I/O space. Everything else is memory.
- Memory space: mem_* = CPU signals, cpu_ack = mem_ack, data_in = mem_out, all combinational. In I/O space, all mem_* outputs are 0.
- I/O handshake: the CPU holds req/load/store/addr/data_out until it sees ack. The block accepts a request in the cycle its condition holds. In the next cycle it drives cpu_ack = 1 for exactly one cycle, with data_in registered. The acked request is ignored for one further cycle, so the CPU can drop req.
- IN load: accepted when the input FIFO is non-empty; pops the head into data_in. If the FIFO is empty and eof = 1, the block sets halt, acks, and drives data_in = 0. If empty and eof = 0, it stalls with no ack.
- OUT store: accepted when the output FIFO is not full; pushes data_out. If full, it stalls.
- STATUS load: always accepted. data_in = {0..., eof, out_full, out_empty, in_empty} in bits [3:0], value sampled at acceptance.
- HALT (any access): sets halt and acks.
- Load to OUT, store to IN, or store to STATUS: acked, no side effect, data_in = 0.
- cpu_halt is a registered sticky flag. Once set, it stays 1 until rst, and further I/O requests are still acked with no side effects.
- Input FIFO fill: in_req = !in_full && !eof && !halt. Push io_in on (in_req && in_ack).
- Output drain: out_req = !out_empty, io_out = head. Pop on (out_req && out_ack). Draining continues after halt.
- Full/empty are evaluated at the start of the cycle. A push and a pop in the same cycle on the same FIFO are both performed, and count is unchanged. A push into a full FIFO is impossible by construction.
- Pointers wrap modulo depth. Count width is clog2(DEPTH)+1.
- Reset: both FIFOs empty, halt = 0, ack state idle. Outputs after reset: cpu_ack = 0, cpu_halt = 0, data_in = 0 (unless in memory space), in_req = !eof, out_req = 0, io_out = 0.
- Reset mid-access discards the pending ack and all FIFO contents.

Decomposition:
- defines.vh holds WORD_SIZE and the MMIO offsets (HALT = 1, OUT = 2, IN = 3, STATUS = 4, counted down from T) plus the status bit indices.
- One sub-module, subleq_fifo (params WIDTH, DEPTH; push/pop/full/empty/head), instantiated twice.
- Decode and ack FSM (IDLE, ACK, GAP) live in the top module.

Test Plan:
- WORD_SIZE = 8, depths 2. Host offers 0x11, 0x22, 0x33 with in_ack always 1 -> in_req drops after 2 pushes. CPU load 0xFD -> data_in = 0x11 with a one-cycle ack. in_req rises and 0x33 enters.
- Output FIFO full, host out_ack = 0. CPU store 0x5A to 0xFE -> no ack. Pulse out_ack once -> 0x5A accepted, ack next cycle, io_out order preserved.
- Input FIFO empty, eof = 1. Load 0xFD -> cpu_ack with data_in = 0x00, cpu_halt = 1 sticky. Subsequent load 0xFC -> acked, returns bit3 = 1.
- Store to 0xFF -> ack, cpu_halt = 1. Output FIFO still drains two queued words to host.
- Memory load at 0x10 with mem_ack/mem_out = 0x7E -> cpu_ack and data_in = 0x7E in the same cycle. in_req/out_req unaffected.
- Simultaneous host push and CPU pop on an input FIFO holding 1 word -> count stays 1, order correct. Assert rst mid-ack -> cpu_ack = 0 and FIFOs empty next cycle.
